// File: rtl/flow_control_status.sv
// Occupancy tracking and flow-control status for five FIFOs (MF, VC0, VC1, D0, D1).
// Outputs are registered from next-state counts/thresholds, so a strobe shows one edge later.
module flow_control_status #(
  parameter int unsigned DEPTH_MF = 4,
  parameter int unsigned DEPTH_VC = 16,
  parameter int unsigned DEPTH_D  = 4
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        init,
  input  logic [13:0] Umbrales_I,
  input  logic [4:0]  push,
  input  logic [4:0]  pop,
  output logic [4:0]  FIFO_empty,
  output logic [4:0]  FIFO_error,
  output logic [4:0]  almost_full,
  output logic [4:0]  almost_empty,
  output logic        pause
);

  logic [4:0] empty_d, err_d, af_d, ae_d;
  logic [4:0] empty_q, err_q, af_q, ae_q;
  logic       pause_q;

  // Bit 4 = MF, 3 = VC0, 2 = VC1, 1 = D0, 0 = D1.
  for (genvar i = 0; i < 5; i++) begin : g_fifo
    localparam bit          IsVc  = (i == 3) || (i == 2);
    localparam int unsigned Depth = (i == 4) ? DEPTH_MF : (IsVc ? DEPTH_VC : DEPTH_D);
    localparam int unsigned CW    = $clog2(Depth + 1);
    localparam int unsigned TW    = IsVc ? 4 : 2;
    localparam int unsigned TLsb  = (i == 4) ? 12 : (i == 3) ? 8 : (i == 2) ? 4 : (i == 1) ? 2 : 0;
    localparam logic [CW-1:0] DepthC = CW'(Depth);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] thr_q, thr_d;
    logic [CW-1:0] thr_ext;
    logic          err_set;

    always_ff @(posedge clk) begin
      if (!reset_L) begin
        cnt_q <= '0;
        thr_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        thr_q <= thr_d;
      end
    end

    always_comb begin
      thr_d   = init ? Umbrales_I[TLsb +: TW] : thr_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      case ({push[i], pop[i]})
        2'b10: begin
          if (cnt_q == DepthC) err_set = 1'b1;
          else                 cnt_d   = cnt_q + CW'(1);
        end
        2'b01: begin
          if (cnt_q == '0) err_set = 1'b1;
          else             cnt_d   = cnt_q - CW'(1);
        end
        2'b11: begin
          // Empty FIFO: the push lands but the pop underflows.
          if (cnt_q == '0) begin
            cnt_d   = CW'(1);
            err_set = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign thr_ext    = CW'(thr_d);
    assign empty_d[i] = (cnt_d == '0);
    assign af_d[i]    = (cnt_d >= (DepthC - thr_ext));
    assign ae_d[i]    = (cnt_d <= thr_ext);
    // Error set wins over the init clear.
    assign err_d[i]   = err_set | (err_q[i] & ~init);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      empty_q <= 5'b11111;
      err_q   <= 5'b00000;
      af_q    <= 5'b00000;
      ae_q    <= 5'b11111;
      pause_q <= 1'b0;
    end else begin
      empty_q <= empty_d;
      err_q   <= err_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      pause_q <= |af_d;
    end
  end

  assign FIFO_empty   = empty_q;
  assign FIFO_error   = err_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign pause        = pause_q;

endmodule

// File: tb/tb_flow_control_status.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations, a monitor compares.
module tb_flow_control_status;

  logic        clk;
  logic        reset_L;
  logic        init;
  logic [13:0] Umbrales_I;
  logic [4:0]  push, pop;
  logic [4:0]  FIFO_empty, FIFO_error, almost_full, almost_empty;
  logic        pause;

  typedef struct {
    logic [4:0] empty;
    logic [4:0] err;
    logic [4:0] af;
    logic [4:0] ae;
    logic       pause;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  flow_control_status dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .Umbrales_I   (Umbrales_I),
    .push         (push),
    .pop          (pop),
    .FIFO_empty   (FIFO_empty),
    .FIFO_error   (FIFO_error),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge with a pending expectation is compared 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({FIFO_empty, FIFO_error, almost_full, almost_empty, pause} !==
          {e.empty, e.err, e.af, e.ae, e.pause}) begin
        errors++;
        $display("FAIL %s: got empty=%b err=%b af=%b ae=%b pause=%b, expected empty=%b err=%b af=%b ae=%b pause=%b",
                 e.name, FIFO_empty, FIFO_error, almost_full, almost_empty, pause,
                 e.empty, e.err, e.af, e.ae, e.pause);
      end
    end
  end

  task automatic step(input logic rst_l, input logic ini, input logic [4:0] pu,
                      input logic [4:0] po, input logic [4:0] x_empty, input logic [4:0] x_err,
                      input logic [4:0] x_af, input logic [4:0] x_ae, input logic x_pause,
                      input string name);
    exp_t e;
    @(negedge clk);
    reset_L = rst_l;
    init    = ini;
    push    = pu;
    pop     = po;
    e.empty = x_empty;
    e.err   = x_err;
    e.af    = x_af;
    e.ae    = x_ae;
    e.pause = x_pause;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_L    = 1'b0;
    init       = 1'b0;
    push       = '0;
    pop        = '0;
    Umbrales_I = {2'd1, 4'd4, 4'd4, 2'd1, 2'd1};

    //   rst init push      pop       empty     err       af        ae        pause
    step(0, 1, 5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b11111, 0, "reset");
    step(1, 1, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b11111, 0, "init_load");
    step(1, 0, 5'b10000, 5'b00000, 5'b01111, 5'b00000, 5'b00000, 5'b11111, 0, "mf_push1");
    step(1, 0, 5'b10000, 5'b00000, 5'b01111, 5'b00000, 5'b00000, 5'b01111, 0, "mf_push2");
    step(1, 0, 5'b10000, 5'b00000, 5'b01111, 5'b00000, 5'b10000, 5'b01111, 1, "mf_push3_af");
    step(1, 0, 5'b10000, 5'b00000, 5'b01111, 5'b00000, 5'b10000, 5'b01111, 1, "mf_push4_full");
    step(1, 0, 5'b10000, 5'b00000, 5'b01111, 5'b10000, 5'b10000, 5'b01111, 1, "mf_overflow");
    step(1, 1, 5'b00000, 5'b00000, 5'b01111, 5'b00000, 5'b10000, 5'b01111, 1, "init_clear");
    step(1, 0, 5'b00000, 5'b00001, 5'b01111, 5'b00001, 5'b10000, 5'b01111, 1, "d1_underflow");
    step(1, 0, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b10000, 5'b01111, 1, "d1_pushpop_at0");
    step(1, 1, 5'b00000, 5'b00001, 5'b01111, 5'b00000, 5'b10000, 5'b01111, 1, "init_with_pop");
    step(1, 1, 5'b00000, 5'b00001, 5'b01111, 5'b00001, 5'b10000, 5'b01111, 1, "init_vs_err");
    step(1, 0, 5'b00000, 5'b10000, 5'b01111, 5'b00001, 5'b10000, 5'b01111, 1, "mf_pop_to3");
    step(1, 0, 5'b00000, 5'b10000, 5'b01111, 5'b00001, 5'b00000, 5'b01111, 0, "mf_pop_to2");

    // VC0 fills to 16 with U=4: almost_empty drops at 5, almost_full rises at 12.
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 5'b01000, 5'b00000, 5'b00111, 5'b00001,
           (k >= 12) ? 5'b01000 : 5'b00000, (k <= 4) ? 5'b01111 : 5'b00111,
           (k >= 12), $sformatf("vc0_push%0d", k));
    end
    step(1, 0, 5'b01000, 5'b01000, 5'b00111, 5'b00001, 5'b01000, 5'b00111, 1, "vc0_pushpop_full");
    step(1, 0, 5'b01000, 5'b00000, 5'b00111, 5'b01001, 5'b01000, 5'b00111, 1, "vc0_overflow");

    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 5'b00100, 5'b00000, 5'b00011, 5'b01001, 5'b01000,
           (k <= 4) ? 5'b00111 : 5'b00011, 1, $sformatf("vc1_push%0d", k));
    end

    step(0, 1, 5'b11111, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b11111, 0, "reset_mid_traffic");
    // Thresholds are zero again after reset.
    step(1, 0, 5'b00010, 5'b00000, 5'b11101, 5'b00000, 5'b00000, 5'b11101, 0, "d0_push_thr0");
    step(1, 0, 5'b10000, 5'b00000, 5'b01101, 5'b00000, 5'b00000, 5'b01101, 0, "mf_thr0_1");
    step(1, 0, 5'b10000, 5'b00000, 5'b01101, 5'b00000, 5'b00000, 5'b01101, 0, "mf_thr0_2");
    step(1, 0, 5'b10000, 5'b00000, 5'b01101, 5'b00000, 5'b00000, 5'b01101, 0, "mf_thr0_3");
    step(1, 0, 5'b10000, 5'b00000, 5'b01101, 5'b00000, 5'b10000, 5'b01101, 1, "mf_thr0_4");

    @(negedge clk);
    push = '0;
    pop  = '0;
    init = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
